// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encoding, button codes and helpers.
// Imported by the direction front end and by the move logic.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'b00;
  localparam dir_t DIR_UP    = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_DOWN  = 2'b11;

  // Buttons are active-low; all-ones means nothing pressed.
  localparam logic [2:0] BTN_NONE  = 3'b111;
  localparam logic [2:0] BTN_UP    = 3'b110;
  localparam logic [2:0] BTN_DOWN  = 3'b101;
  localparam logic [2:0] BTN_RIGHT = 3'b100;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce counter for a vector of raw buttons.
// Emits the accepted (stable) vector and a one-cycle pulse whenever it changes.
module btn_debounce #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             chg
);

  localparam logic [CNT_W-1:0] DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      cand    <= '1;
      cnt     <= '0;
      stable  <= '1;
      chg     <= 1'b0;
    end else begin
      // synchronizer stages
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      chg     <= 1'b0;
      // debounce stage: accept on the cycle the counter reaches DONE, then hold it there
      if (sync_p1 != cand) begin
        cand <= sync_p1;
        cnt  <= '0;
      end else if (cnt != DONE) begin
        cnt <= cnt + 1'b1;
        if (cnt == DONE - 1'b1) begin
          stable <= cand;
          chg    <= (cand != stable);
        end
      end
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// Snake direction front end: debounced buttons -> direction request -> pending
// request committed on the move tick, with reversals dropped.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       pend_valid,
  output logic       dir_chg,
  output logic       rejected
);

  logic [2:0] btn_stable;
  logic       btn_chg;
  logic       req_stb;
  dir_t       req_dir;
  dir_t       pend_dir;

  function automatic dir_t decode(input logic [2:0] code);
    dir_t d;
    if (!code[2])               d = DIR_LEFT;
    else if (code == BTN_DOWN)  d = DIR_DOWN;
    else if (code == BTN_UP)    d = DIR_UP;
    else                        d = DIR_RIGHT;
    return d;
  endfunction

  btn_debounce #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .din   (button),
    .stable(btn_stable),
    .chg   (btn_chg)
  );

  // decode stage: a release to all-ones produces no request
  assign req_stb = btn_chg && (btn_stable != BTN_NONE);
  assign req_dir = decode(btn_stable);

  always_ff @(posedge clk) begin
    if (req_stb) pend_dir <= req_dir;
  end

  // commit stage: the tick consumes the request held before this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir        <= DIR_DOWN;
      pend_valid <= 1'b0;
      dir_chg    <= 1'b0;
      rejected   <= 1'b0;
    end else begin
      dir_chg  <= 1'b0;
      rejected <= 1'b0;
      if (tick && pend_valid) begin
        if (pend_dir == opposite(dir)) begin
          rejected <= 1'b1;
        end else begin
          dir     <= pend_dir;
          dir_chg <= (pend_dir != dir);
        end
      end
      if (req_stb)   pend_valid <= 1'b1;
      else if (tick) pend_valid <= 1'b0;
    end
  end

endmodule
